// File: rtl/riscv_mem_arbiter_if.sv
// Bundle of imem/dmem/memory request-response channels around riscv_mem_arbiter.
// slave is the arbiter's view; master is the core + memory side driving it.
interface riscv_mem_arbiter_if #(
    parameter int p_req_sz  = 67,
    parameter int p_resp_sz = 35
);
    logic [p_req_sz-1:0]  imemreq_msg;
    logic                 imemreq_val;
    logic                 imemreq_rdy;
    logic [p_resp_sz-1:0] imemresp_msg;
    logic                 imemresp_val;

    logic [p_req_sz-1:0]  dmemreq_msg;
    logic                 dmemreq_val;
    logic                 dmemreq_rdy;
    logic [p_resp_sz-1:0] dmemresp_msg;
    logic                 dmemresp_val;

    logic [p_req_sz-1:0]  memreq_msg;
    logic                 memreq_val;
    logic                 memreq_rdy;
    logic [p_resp_sz-1:0] memresp_msg;
    logic                 memresp_val;

    modport slave (
        input  imemreq_msg, imemreq_val,
        output imemreq_rdy, imemresp_msg, imemresp_val,
        input  dmemreq_msg, dmemreq_val,
        output dmemreq_rdy, dmemresp_msg, dmemresp_val,
        output memreq_msg, memreq_val,
        input  memreq_rdy, memresp_msg, memresp_val
    );

    modport master (
        output imemreq_msg, imemreq_val,
        input  imemreq_rdy, imemresp_msg, imemresp_val,
        output dmemreq_msg, dmemreq_val,
        input  dmemreq_rdy, dmemresp_msg, dmemresp_val,
        input  memreq_msg, memreq_val,
        output memreq_rdy, memresp_msg, memresp_val
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Shares one in-order memory port between imem and dmem; an ID FIFO routes responses back.
// Round-robin by default; define RISCV_MEM_ARB_DPRIO_EN for fixed dmem priority.
module riscv_mem_arbiter #(
    parameter int p_max_out = 4,
    parameter int p_req_sz  = 67,
    parameter int p_resp_sz = 35
) (
    input  logic                        clk,
    input  logic                        reset,
    riscv_mem_arbiter_if.slave          bus,
    output logic [$clog2(p_max_out):0]  outstanding,
    output logic                        err
);
    localparam int PW = $clog2(p_max_out);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAX_OUT = CW'(p_max_out);
    localparam logic ID_IMEM = 1'b0;

    logic [p_max_out-1:0] id_fifo_q, id_fifo_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 last_grant_q, last_grant_d;
    logic                 err_q, err_d;

    logic full, empty, grant_en, any_val, winner;
    logic mreq_val, fire, pop, stray, head_id;

    // Grant and response routing are purely combinational.
    always_comb begin
        full     = (cnt_q == MAX_OUT);
        empty    = (cnt_q == '0);
        grant_en = reset & ~full;
        any_val  = bus.imemreq_val | bus.dmemreq_val;
`ifdef RISCV_MEM_ARB_DPRIO_EN
        winner   = bus.dmemreq_val;
`else
        winner   = (bus.imemreq_val & bus.dmemreq_val) ? ~last_grant_q : bus.dmemreq_val;
`endif
        mreq_val = any_val & grant_en;
        fire     = mreq_val & bus.memreq_rdy;
        head_id  = id_fifo_q[rd_ptr_q];
        pop      = reset & bus.memresp_val & ~empty;
        stray    = bus.memresp_val & empty;
    end

    always_comb begin
        bus.memreq_val   = mreq_val;
        bus.memreq_msg   = (any_val & winner) ? bus.dmemreq_msg : bus.imemreq_msg;
        bus.imemreq_rdy  = bus.imemreq_val & ~winner & bus.memreq_rdy & grant_en;
        bus.dmemreq_rdy  = bus.dmemreq_val &  winner & bus.memreq_rdy & grant_en;
        bus.imemresp_msg = bus.memresp_msg;
        bus.dmemresp_msg = bus.memresp_msg;
        bus.imemresp_val = pop & ~head_id;
        bus.dmemresp_val = pop &  head_id;
    end

    always_comb begin
        id_fifo_d    = id_fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        if (fire) begin
            id_fifo_d[wr_ptr_q] = winner;
            wr_ptr_d            = wr_ptr_q + 1'b1;
            last_grant_d        = winner;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        case ({fire, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // Sticky until reset: a response with nothing outstanding means a lost ID.
        if (stray)
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            id_fifo_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            last_grant_q <= ID_IMEM;
            err_q        <= 1'b0;
        end else begin
            id_fifo_q    <= id_fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    assign outstanding = cnt_q;
    assign err         = err_q;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: vector table, directed corner sequences, random vs queue model.
module tb_riscv_mem_arbiter;
    localparam int MAXO = 4;
    localparam int RQ   = 67;
    localparam int RS   = 35;
    localparam int CW   = $clog2(MAXO) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CW-1:0] outstanding;
    logic          err;

    riscv_mem_arbiter_if #(.p_req_sz(RQ), .p_resp_sz(RS)) bus ();

    riscv_mem_arbiter #(.p_max_out(MAXO), .p_req_sz(RQ), .p_resp_sz(RS)) dut (
        .clk(clk), .reset(reset), .bus(bus), .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: queue of requester IDs in issue order, last winner, sticky error.
    int idq[$];
    bit m_last = 1'b0;
    bit m_err  = 1'b0;
    bit s_fire, s_win;
    logic [RQ-1:0] imsg = 67'h1_1111_2222_3333_4444;
    logic [RQ-1:0] dmsg = 67'h6_aaaa_bbbb_cccc_dddd;

    typedef struct {
        bit iv, dv, mrdy, rv;
        bit e_mval, e_irdy, e_drdy, e_ir, e_dr;
        int e_out;
        bit e_err;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_winner(input bit iv, input bit dv);
        if (iv && dv) begin
`ifdef RISCV_MEM_ARB_DPRIO_EN
            return 1'b1;
`else
            return !m_last;
`endif
        end
        return dv;
    endfunction

    task automatic eval();
        bit in_rst, full, any, win, rv, e_mval, e_ir, e_dr;
        in_rst = !reset;
        full   = idq.size() >= MAXO;
        any    = bus.imemreq_val | bus.dmemreq_val;
        win    = m_winner(bus.imemreq_val, bus.dmemreq_val);
        rv     = bus.memresp_val;
        e_mval = any && !full && !in_rst;
        e_ir   = !in_rst && rv && idq.size() > 0 && idq[0] == 0;
        e_dr   = !in_rst && rv && idq.size() > 0 && idq[0] == 1;
        chk("memreq_val", bus.memreq_val, e_mval);
        chk("imemreq_rdy", bus.imemreq_rdy, e_mval && bus.memreq_rdy && !win);
        chk("dmemreq_rdy", bus.dmemreq_rdy, e_mval && bus.memreq_rdy && win);
        chk("memreq_msg", bus.memreq_msg, (any && win) ? dmsg : imsg);
        chk("imemresp_val", bus.imemresp_val, e_ir);
        chk("dmemresp_val", bus.dmemresp_val, e_dr);
        chk("imemresp_msg", bus.imemresp_msg, bus.memresp_msg);
        chk("dmemresp_msg", bus.dmemresp_msg, bus.memresp_msg);
        chk("outstanding", outstanding, idq.size());
        chk("err", err, m_err);
        s_fire = e_mval && bus.memreq_rdy;
        s_win  = win;
        if (in_rst) begin
            idq.delete();
            m_last = 1'b0;
            m_err  = 1'b0;
        end else begin
            if (rv) begin
                if (idq.size() > 0) void'(idq.pop_front());
                else m_err = 1'b1;
            end
            if (s_fire) begin
                idq.push_back(int'(win));
                m_last = win;
            end
        end
    endtask

    // Drive right after the edge, check on the falling edge.
    task automatic half(input bit iv, input bit dv, input bit mrdy, input bit rv, input logic [RS-1:0] rm);
        bus.imemreq_val = iv;
        bus.dmemreq_val = dv;
        bus.imemreq_msg = imsg;
        bus.dmemreq_msg = dmsg;
        bus.memreq_rdy  = mrdy;
        bus.memresp_val = rv;
        bus.memresp_msg = rm;
        #4;
        eval();
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit iv, input bit dv, input bit mrdy, input bit rv, input logic [RS-1:0] rm);
        half(iv, dv, mrdy, rv, rm);
        fin();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int fires;
        logic [31:0] rdat[4];
        bit          rdst[4];

        tbl[0]  = '{1,1,1,0, 1,0,1,0,0, 0,0};
`ifdef RISCV_MEM_ARB_DPRIO_EN
        tbl[1]  = '{1,1,1,1, 1,0,1,0,1, 1,0};
        tbl[2]  = '{1,1,1,1, 1,0,1,0,1, 1,0};
        tbl[3]  = '{1,1,1,1, 1,0,1,0,1, 1,0};
        tbl[4]  = '{0,0,1,1, 0,0,0,0,1, 1,0};
`else
        tbl[1]  = '{1,1,1,1, 1,1,0,0,1, 1,0};
        tbl[2]  = '{1,1,1,1, 1,0,1,1,0, 1,0};
        tbl[3]  = '{1,1,1,1, 1,1,0,0,1, 1,0};
        tbl[4]  = '{0,0,1,1, 0,0,0,1,0, 1,0};
`endif
        tbl[5]  = '{0,0,1,1, 0,0,0,0,0, 0,0};
        tbl[6]  = '{1,0,0,0, 1,0,0,0,0, 0,1};
        tbl[7]  = '{1,0,1,0, 1,1,0,0,0, 0,1};
        tbl[8]  = '{0,1,1,0, 1,0,1,0,0, 1,1};
        tbl[9]  = '{0,0,1,1, 0,0,0,1,0, 2,1};
        tbl[10] = '{0,0,1,1, 0,0,0,0,1, 1,1};
        tbl[11] = '{0,0,0,0, 0,0,0,0,0, 0,1};

        bus.imemreq_val = 1'b0; bus.dmemreq_val = 1'b0;
        bus.imemreq_msg = imsg; bus.dmemreq_msg = dmsg;
        bus.memreq_rdy  = 1'b0; bus.memresp_val = 1'b0; bus.memresp_msg = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Vector table straight out of reset.
        for (int i = 0; i < 12; i++) begin
            half(tbl[i].iv, tbl[i].dv, tbl[i].mrdy, tbl[i].rv, RS'(i));
            chk($sformatf("tbl%0d_mval", i), bus.memreq_val, tbl[i].e_mval);
            chk($sformatf("tbl%0d_irdy", i), bus.imemreq_rdy, tbl[i].e_irdy);
            chk($sformatf("tbl%0d_drdy", i), bus.dmemreq_rdy, tbl[i].e_drdy);
            chk($sformatf("tbl%0d_iresp", i), bus.imemresp_val, tbl[i].e_ir);
            chk($sformatf("tbl%0d_dresp", i), bus.dmemresp_val, tbl[i].e_dr);
            chk($sformatf("tbl%0d_out", i), outstanding, tbl[i].e_out);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
            fin();
        end

        // Single imem fetch, response two cycles later.
        do_reset();
        half(1'b1, 1'b0, 1'b1, 1'b0, '0);
        chk("fetch_out0", outstanding, 0);
        fin();
        half(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("fetch_out1", outstanding, 1);
        fin();
        half(1'b0, 1'b0, 1'b0, 1'b1, 35'h13);
        chk("fetch_ival", bus.imemresp_val, 1'b1);
        chk("fetch_data", bus.imemresp_msg[31:0], 32'h0000_0013);
        chk("fetch_dval", bus.dmemresp_val, 1'b0);
        fin();
        half(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("fetch_out2", outstanding, 0);
        fin();

        // Fill the ID FIFO; a pop while full must not grant in the same cycle.
        do_reset();
        fires = 0;
        for (int i = 0; i < 6; i++) begin
            half(1'b0, 1'b1, 1'b1, 1'b0, '0);
            fires += int'(bus.dmemreq_rdy);
            fin();
        end
        chk("fill_fires", fires, 4);
        half(1'b0, 1'b1, 1'b1, 1'b1, '0);
        chk("fill_out", outstanding, 4);
        chk("fill_drdy", bus.dmemreq_rdy, 1'b0);
        fires += int'(bus.dmemreq_rdy);
        fin();
        half(1'b0, 1'b1, 1'b1, 1'b0, '0);
        chk("refill_drdy", bus.dmemreq_rdy, 1'b1);
        fires += int'(bus.dmemreq_rdy);
        fin();
        chk("refill_fires", fires, 5);
        half(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("refill_out", outstanding, 4);
        fin();

        // Interleaved I,D,D,I with in-order responses.
        do_reset();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
        rdat = '{32'hA, 32'hB, 32'hC, 32'hD};
        rdst = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            half(1'b0, 1'b0, 1'b0, 1'b1, RS'(rdat[i]));
            chk($sformatf("ileave%0d_ival", i), bus.imemresp_val, !rdst[i]);
            chk($sformatf("ileave%0d_dval", i), bus.dmemresp_val, rdst[i]);
            chk($sformatf("ileave%0d_data", i),
                rdst[i] ? bus.dmemresp_msg[31:0] : bus.imemresp_msg[31:0], rdat[i]);
            fin();
        end

        // Stray response sets a sticky error cleared only by reset.
        half(1'b0, 1'b0, 1'b0, 1'b1, 35'h77);
        chk("stray_ival", bus.imemresp_val, 1'b0);
        chk("stray_dval", bus.dmemresp_val, 1'b0);
        fin();
        for (int i = 0; i < 3; i++) begin
            half(1'b0, 1'b0, 1'b0, 1'b0, '0);
            chk($sformatf("stray_hold%0d", i), err, 1'b1);
            fin();
        end
        do_reset();
        half(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("stray_clr", err, 1'b0);
        fin();

        // Reset with three outstanding requests.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
        reset = 1'b0;
        half(1'b1, 1'b1, 1'b1, 1'b1, '0);
        chk("rst_out3", outstanding, 3);
        chk("rst_mval", bus.memreq_val, 1'b0);
        chk("rst_irdy", bus.imemreq_rdy, 1'b0);
        chk("rst_drdy", bus.dmemreq_rdy, 1'b0);
        chk("rst_ival", bus.imemresp_val, 1'b0);
        chk("rst_dval", bus.dmemresp_val, 1'b0);
        fin();
        reset = 1'b1;
        half(1'b1, 1'b1, 1'b1, 1'b0, '0);
        chk("rst_out0", outstanding, 0);
        chk("rst_tie_d", bus.dmemreq_rdy, 1'b1);
        chk("rst_tie_i", bus.imemreq_rdy, 1'b0);
        fin();
        half(1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk("rst_after_pop", bus.dmemresp_val, 1'b1);
        fin();

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            bit iv, dv, mrdy, rv;
            reset = ($urandom_range(0, 63) != 0);
            iv    = $urandom_range(0, 1) == 1;
            dv    = $urandom_range(0, 1) == 1;
            mrdy  = $urandom_range(0, 3) != 0;
            rv    = ($urandom_range(0, 2) == 0) && (idq.size() > 0 || $urandom_range(0, 15) == 0);
            cyc(iv, dv, mrdy, rv, RS'({$urandom(), $urandom()}));
            if (s_fire && !s_win) imsg = RQ'({$urandom(), $urandom(), $urandom()});
            if (s_fire &&  s_win) dmsg = RQ'({$urandom(), $urandom(), $urandom()});
        end
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
